pipe_stall_ctrl: RTL

Central stall/flush controller for the five-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB registers). It merges stall requests from ID (load-use), EX (multi-cycle ops such as madd/msub/div) and MEM (data-memory wait) into one per-stage stall vector, and broadcasts a flush on exceptions. It also sequences EX multi-cycle operations with an internal counter FSM, so EX holds its operands for exactly N cycles. A saturating stall-cycle performance counter is included.

---
 rtl/pipe_stall_if.sv | 26 ++
 rtl/pipe_stall_ctrl.sv | 58 +++++
 2 files changed

// File: rtl/pipe_stall_if.sv
// pipe_stall_if: request/response bundle between the pipeline stages and the stall controller
interface pipe_stall_if #(
    parameter int N_MC_CYC = 6,
    parameter int N_PERF   = 16
);
    logic                id_stallreq;
    logic                ex_mc_req;
    logic [N_MC_CYC-1:0] ex_mc_cycles;
    logic                mem_stallreq;
    logic                flush_req;
    logic [5:0]          stall;
    logic                flush;
    logic                ex_mc_busy;
    logic                ex_mc_done;
    logic [N_PERF-1:0]   stall_cnt;

    modport master (
        output id_stallreq, ex_mc_req, ex_mc_cycles, mem_stallreq, flush_req,
        input  stall, flush, ex_mc_busy, ex_mc_done, stall_cnt
    );

    modport slave (
        input  id_stallreq, ex_mc_req, ex_mc_cycles, mem_stallreq, flush_req,
        output stall, flush, ex_mc_busy, ex_mc_done, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges stage stall requests, sequences EX multi-cycle ops, counts stall cycles
module pipe_stall_ctrl #(
    parameter int N_MC_CYC = 6,
    parameter int N_PERF   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    pipe_stall_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [N_MC_CYC-1:0] cnt;
    logic [N_PERF-1:0]   perf;
    logic                long_op;
    logic                ex_stall;

    // Stall vector and done are pure functions of state, cnt and the live requests
    always_comb begin
        long_op        = bus.ex_mc_cycles >= N_MC_CYC'(2);
        ex_stall       = (state == IDLE) ? bus.ex_mc_req && long_op : cnt != '0;
        bus.ex_mc_done = !bus.flush_req && ((state == IDLE) ? bus.ex_mc_req && !long_op : cnt == '0);
        bus.stall      = bus.flush_req    ? 6'b000000 :
                         bus.mem_stallreq ? 6'b011111 :
                         ex_stall         ? 6'b001111 :
                         bus.id_stallreq  ? 6'b000111 : 6'b000000;
    end

    assign bus.flush      = bus.flush_req;
    assign bus.ex_mc_busy = state == BUSY;
    assign bus.stall_cnt  = perf;

    // Multi-cycle FSM: cnt counts the remaining stall cycles; done holds while MEM keeps EX/MEM frozen
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.flush_req) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (bus.ex_mc_req && long_op) begin
                state <= BUSY;
                cnt   <= bus.ex_mc_cycles - N_MC_CYC'(2);
            end
        end else if (cnt != '0) begin
            cnt <= cnt - N_MC_CYC'(1);
        end else if (!bus.stall[3]) begin
            state <= IDLE;
        end
    end

    // Saturating count of cycles in which any register is held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) perf <= '0;
        else if (bus.stall != '0 && perf != '1) perf <= perf + N_PERF'(1);
    end
endmodule
